cacheline_mem_arbiter: RTL and testbench
========================================

Name: cacheline_mem_arbiter

Overview:
- Shares the single cacheline-level physical memory port (upstream of the burst cacheline adaptor) between the icache and dcache miss paths.
- Sits between the two caches' pmem-side interfaces and the adaptor inside the mp4 top level.
- Serves one 256-bit line transaction at a time.
- Dcache has priority; a bounded starvation guard protects the icache.

Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, physical address width
- STARVE_LIMIT, 4, consecutive dcache grants with icache waiting before icache is forced; 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  icache line read request, level, held until i_resp
- i_addr  in  ADDR_W  icache line address (low 5 bits ignored, driven as 0 downstream)
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  one-cycle completion to icache
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line writeback request, held until d_resp
- d_addr  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  one-cycle completion to dcache
- mem_read  out  1  to adaptor
- mem_write  out  1  to adaptor
- mem_addr  out  ADDR_W  to adaptor, low 5 bits zero
- mem_wdata  out  LINE_W  to adaptor
- mem_rdata  in  LINE_W  from adaptor
- mem_resp  in  1  from adaptor, one cycle per transaction

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- States: IDLE, I_BUSY, D_BUSY, DONE.
- Reset state and values:
  - state = IDLE, starve_cnt = 0.
  - Latched addr/wdata/op = 0.
  - All outputs 0.
- IDLE arbitration:
  - Dcache request (d_read|d_write) wins when starve_cnt < STARVE_LIMIT or i_read = 0.
  - Otherwise the icache wins.
  - On a grant: latch address (low 5 bits cleared), wdata and op, then go to I_BUSY/D_BUSY next edge.
  - Grant latency is 1 cycle from request to mem_read/mem_write high.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each dcache grant while i_read = 1.
  - Clears on an icache grant, or whenever i_read = 0 in IDLE.
- BUSY states:
  - mem_read/mem_write are driven from the latched op; mem_addr/mem_wdata from the latches.
  - Outputs are stable for the whole transaction, regardless of input changes.
- Simultaneous d_read & d_write is illegal; the write is taken.
- Response routing:
  - On mem_resp in X_BUSY: X_resp = 1 for exactly that cycle (combinational from mem_resp and state).
  - The requester sees resp in the same cycle as mem_resp.
  - i_rdata and d_rdata are both wired to mem_rdata at all times; only resp is qualified.
  - mem_read/mem_write drop the cycle after mem_resp; state moves to DONE.
- DONE:
  - One bubble cycle that lets the requester deassert; no grant is issued.
  - Then IDLE. Back-to-back transactions are therefore spaced by at least 2 idle cycles on mem_*.
- mem_resp seen in IDLE/DONE: ignored, no resp is generated.
- A requester dropping its request mid-transaction is a protocol violation; the arbiter completes the transaction anyway and still pulses resp.
- rst_n low mid-transaction:
  - Immediate return to reset values.
  - The adaptor shares rst_n, so no partial transaction resumes.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_i_wait[31:0].
  - perf_i_wait counts cycles with i_read = 1 and no icache grant active.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: no counters, no extra ports, identical arbitration behaviour.

Decomposition:
- Shared package mem_arb_types: state enum arb_state_t {IDLE, I_BUSY, D_BUSY, DONE}, LINE_OFFSET_BITS = 5, and the source-id enum {SRC_I, SRC_D}.
- One sub-module is natural: arb_starve_ctr, holding the saturating starvation counter and its force_i output.
- The FSM and muxing stay in the top.

Test Plan:
- Lone icache read: i_read=1, i_addr=0x0000_0064 -> mem_read=1, mem_addr=0x0000_0060 one cycle later; mem_resp with mem_rdata=0xA5..A5 -> i_resp=1 the same cycle, i_rdata=0xA5..A5, d_resp=0.
- Dcache writeback: d_write=1, d_addr=0x8000_0020, d_wdata pattern -> mem_write=1, mem_wdata equals the pattern; d_resp pulses with mem_resp; state passes through DONE before IDLE.
- Simultaneous i_read and d_read from reset -> dcache granted first; icache granted right after DONE; each resp pulses exactly once.
- Starvation: STARVE_LIMIT=4, i_read held high, dcache requesting continuously -> 4 dcache grants, then the 5th grant goes to the icache; starve_cnt returns to 0.
- Reset mid-D_BUSY: pull rst_n low asynchronously -> mem_read/mem_write/resp go to 0 without waiting for clk; a later stray mem_resp in IDLE produces no resp.
- MEM_ARB_PERF_EN build: 3 icache + 2 dcache transactions -> perf_i_grants=3, perf_d_grants=2, and perf_i_wait equals the counted blocked cycles.

Source files
------------

// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cacheline memory arbiter: FSM states, source ids, line geometry.
// Types only; no latency or backpressure of its own.
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/cacheline_mem_arbiter_starve_ctr.sv
// Saturating count of dcache wins over a waiting icache; force_i_o is a registered flag, 0-cycle to the arbiter.
// No backpressure: it only observes grants.
module arb_starve_ctr
  import mem_arb_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_idle_i,
  input  logic                    i_read_i,
  input  logic                    d_grant_i,
  input  logic                    i_grant_i,
  output logic                    force_i_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // The icache stops waiting either by being served or by giving up its request.
    if (i_grant_i || (in_idle_i && !i_read_i)) begin
      cnt_d = '0;
    end else if (d_grant_i && i_read_i && (cnt_q < LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_i_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one cacheline memory port between icache and dcache; grant 1 cycle after request, resp same cycle as mem_resp.
// Requesters hold until resp; one transaction plus a DONE bubble at a time. MEM_ARB_PERF_EN adds grant/wait counters.
module cacheline_mem_arbiter
  import mem_arb_types::*;
#(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_i_wait
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {{(ADDR_W-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              d_req, force_i, grant_d, grant_i, busy;
  src_t              grant_src;

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_idle_i (state_q == IDLE),
    .i_read_i  (i_read),
    .d_grant_i (grant_d),
    .i_grant_i (grant_i),
    .force_i_o (force_i)
  );

  always_comb begin
    d_req     = d_read | d_write;
    grant_src = (d_req && !(force_i && i_read)) ? SRC_D : SRC_I;
    grant_d   = (state_q == IDLE) && d_req && (grant_src == SRC_D);
    grant_i   = (state_q == IDLE) && i_read && (grant_src == SRC_I);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          // An illegal read+write pair resolves to the writeback.
          addr_d  = d_addr & ALIGN_MASK;
          wdata_d = d_wdata;
          write_d = d_write;
          state_d = D_BUSY;
        end else if (grant_i) begin
          addr_d  = i_addr & ALIGN_MASK;
          wdata_d = '0;
          write_d = 1'b0;
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign busy      = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign mem_read  = busy && !write_q;
  assign mem_write = busy && write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_resp    = (state_q == I_BUSY) && mem_resp;
  assign d_resp    = (state_q == D_BUSY) && mem_resp;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants_q, perf_d_grants_q, perf_i_wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants_q <= '0;
      perf_d_grants_q <= '0;
      perf_i_wait_q   <= '0;
    end else begin
      if (grant_i) perf_i_grants_q <= perf_i_grants_q + 32'd1;
      if (grant_d) perf_d_grants_q <= perf_d_grants_q + 32'd1;
      if (i_read && (state_q != I_BUSY)) perf_i_wait_q <= perf_i_wait_q + 32'd1;
    end
  end

  assign perf_i_grants = perf_i_grants_q;
  assign perf_d_grants = perf_d_grants_q;
  assign perf_i_wait   = perf_i_wait_q;
`endif

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Scoreboarded bench for cacheline_mem_arbiter: the bench plays both caches and the adaptor.
module tb_cacheline_mem_arbiter;
  import mem_arb_types::*;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  typedef struct {
    logic              wr;
    logic              src_d;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  cacheline_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void push_exp(input logic wr, input logic src_d,
                                   input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
    exp_t e;
    e.wr = wr; e.src_d = src_d; e.addr = a; e.wdata = w;
    exp_q.push_back(e);
  endfunction

  task automatic drive_quiet();
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_quiet();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Adaptor side: wait for a transaction, score it, answer after lat cycles, release the requester.
  task automatic serve(input int lat, input logic [LINE_W-1:0] rd, input bit scramble,
                       output int waited);
    exp_t e;
    int n;
    logic [LINE_W-1:0] got_rd;
    n = 0;
    @(negedge clk);
    while (!(mem_read || mem_write) && n < 40) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    total_cnt++;
    if (!(mem_read || mem_write)) begin
      $display("FAIL serve_start: no mem request after %0d cycles, required one", n);
      return;
    end else pass_cnt++;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty: DUT started a transaction at %h, none expected", mem_addr);
      return;
    end else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({mem_write, mem_read} !== {e.wr, !e.wr})
      $display("FAIL op: got wr/rd=%b%b required %b%b", mem_write, mem_read, e.wr, !e.wr);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== e.addr || mem_wdata !== e.wdata)
      $display("FAIL addr_wdata: got %h/%h required %h/%h", mem_addr, mem_wdata, e.addr, e.wdata);
    else pass_cnt++;
    if (scramble) begin
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = {8{$urandom}};
    end
    repeat (lat) @(negedge clk);
    total_cnt++;
    if ({mem_write, mem_read} !== {e.wr, !e.wr} || mem_addr !== e.addr || mem_wdata !== e.wdata)
      $display("FAIL stable: got wr=%b rd=%b addr=%h required wr=%b addr=%h",
               mem_write, mem_read, mem_addr, e.wr, e.addr);
    else pass_cnt++;
    mem_resp  = 1'b1;
    mem_rdata = rd;
    #1;
    got_rd = e.src_d ? d_rdata : i_rdata;
    total_cnt++;
    if ({i_resp, d_resp} !== (e.src_d ? 2'b01 : 2'b10))
      $display("FAIL resp_route: got i/d=%b%b required %b", i_resp, d_resp,
               (e.src_d ? 2'b01 : 2'b10));
    else pass_cnt++;
    total_cnt++;
    if (got_rd !== rd)
      $display("FAIL rdata: got %h required %h", got_rd, rd);
    else pass_cnt++;
    @(posedge clk);
    #1;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    if (e.src_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    @(negedge clk);
    total_cnt++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || dut.state_q !== DONE)
      $display("FAIL done_bubble: got rd/wr/iresp/dresp=%b%b%b%b state=%0d required 0000 state=%0d",
               mem_read, mem_write, i_resp, d_resp, dut.state_q, DONE);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_quiet();
    #3;
    total_cnt++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0)
      $display("FAIL reset_ctrl: got %b required 0000", {mem_read, mem_write, i_resp, d_resp});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_data: got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== IDLE || dut.u_starve.cnt_q !== 4'd0)
      $display("FAIL reset_state: got state=%0d cnt=%0d required 0/0", dut.state_q, dut.u_starve.cnt_q);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0)
      $display("FAIL idle_quiet: got %b required 0000", {mem_read, mem_write, i_resp, d_resp});
    else pass_cnt++;
  endtask

  task automatic test_lone_iread();
    int w;
    do_reset();
    i_addr = 32'h0000_0064;
    i_read = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0000_0060, '0);
    serve(2, {32{8'hA5}}, 1'b1, w);
    total_cnt++;
    if (w !== 1) $display("FAIL grant_latency: got %0d wait cycles required 1", w);
    else pass_cnt++;
  endtask

  task automatic test_dwrite();
    int w;
    logic [LINE_W-1:0] pat;
    pat = {4{64'h0123_4567_89AB_CDEF}};
    do_reset();
    d_addr  = 32'h8000_0020;
    d_wdata = pat;
    d_write = 1'b1;
    push_exp(1'b1, 1'b1, 32'h8000_0020, pat);
    serve(3, '0, 1'b1, w);
    @(negedge clk);
    total_cnt++;
    if (dut.state_q !== IDLE) $display("FAIL done_to_idle: got state=%0d required %0d", dut.state_q, IDLE);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int w1, w2;
    do_reset();
    i_addr  = 32'h1234_5678;
    d_addr  = 32'h0000_1FFF;
    d_wdata = 256'h77;
    i_read  = 1'b1;
    d_read  = 1'b1;
    push_exp(1'b0, 1'b1, 32'h0000_1FE0, 256'h77);
    push_exp(1'b0, 1'b0, 32'h1234_5660, '0);
    serve(1, {8{32'hCAFE_0001}}, 1'b0, w1);
    serve(1, {8{32'hCAFE_0002}}, 1'b0, w2);
    total_cnt++;
    if (w2 !== 1) $display("FAIL back_to_back_gap: got %0d extra waits required 1", w2);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0)
      $display("FAIL single_resp: got %b required 0000", {mem_read, mem_write, i_resp, d_resp});
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    int w;
    do_reset();
    i_addr = 32'h4000_0040;
    i_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_addr = 32'h100 * (k + 1);
      d_read = 1'b1;
      push_exp(1'b0, 1'b1, 32'h100 * (k + 1), '0);
      serve(1, {8{32'h5000_0000 + k}}, 1'b0, w);
    end
    total_cnt++;
    if (dut.u_starve.cnt_q !== 4'd4) $display("FAIL starve_sat: got %0d required 4", dut.u_starve.cnt_q);
    else pass_cnt++;
    d_addr = 32'h0000_0900;
    d_read = 1'b1;
    push_exp(1'b0, 1'b0, 32'h4000_0040, '0);
    push_exp(1'b0, 1'b1, 32'h0000_0900, '0);
    serve(1, {8{32'h1111_2222}}, 1'b0, w);
    total_cnt++;
    if (dut.u_starve.cnt_q !== 4'd0) $display("FAIL starve_clear: got %0d required 0", dut.u_starve.cnt_q);
    else pass_cnt++;
    serve(1, {8{32'h3333_4444}}, 1'b0, w);
  endtask

  task automatic test_rw_conflict();
    int w;
    logic [LINE_W-1:0] pat;
    pat = {8{32'h0F0F_A5A5}};
    do_reset();
    d_addr  = 32'h0000_0ABC;
    d_wdata = pat;
    d_read  = 1'b1;
    d_write = 1'b1;
    push_exp(1'b1, 1'b1, 32'h0000_0AA0, pat);
    serve(1, '0, 1'b0, w);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n;
    do_reset();
    d_addr  = 32'h0000_0055;
    d_wdata = 256'h1;
    d_read  = 1'b1;
    push_exp(1'b0, 1'b1, 32'h0000_0040, 256'h1);
    n = 0;
    @(negedge clk);
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!mem_read || exp_q.size() == 0) begin
      $display("FAIL mid_start: got mem_read=%b required 1", mem_read);
    end else begin
      e = exp_q.pop_front();
      if (mem_addr !== e.addr) $display("FAIL mid_addr: got %h required %h", mem_addr, e.addr);
      else pass_cnt++;
    end
    mem_resp = 1'b1;
    #1;
    total_cnt++;
    if (d_resp !== 1'b1) $display("FAIL mid_resp_pre: got %b required 1", d_resp);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || mem_addr !== '0)
      $display("FAIL async_reset: got ctrl=%b addr=%h required 0000/0",
               {mem_read, mem_write, i_resp, d_resp}, mem_addr);
    else pass_cnt++;
    mem_resp = 1'b0;
    d_read   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    total_cnt++;
    if ({i_resp, d_resp} !== 2'b00) $display("FAIL stray_resp: got %b required 00", {i_resp, d_resp});
    else pass_cnt++;
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({mem_read, mem_write} !== 2'b00 || dut.state_q !== IDLE)
      $display("FAIL stray_ignored: got rd/wr=%b state=%0d required 00/%0d",
               {mem_read, mem_write}, dut.state_q, IDLE);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lone_iread();
    test_dwrite();
    test_simultaneous();
    test_starvation();
    test_rw_conflict();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
